// File: rtl/out_port_bcd.sv
// -----------------------------------------------------------------------------
// out_port_bcd
//
// Memory-mapped output port feeding the two-digit seven-segment display stage.
// A CPU store to PORT_ADDR is captured as the port value, and the value is
// converted to two BCD digits by a sequential shift-and-add-3 (double-dabble)
// converter. The digits and the overflow flag are registered and change only
// when a conversion commits, so the display never sees intermediate results.
//
// Ports:
//   clock      in   1   system clock, rising-edge active
//   resetn     in   1   asynchronous active-low reset
//   addr       in  32   CPU data-memory address
//   wdata      in  32   CPU store data
//   we         in   1   CPU store strobe (accepted when addr == PORT_ADDR)
//   port_data  out 32   last accepted store data (full 32 bits)
//   digit_ten  out  4   BCD tens digit, 0..9
//   digit_mod  out  4   BCD units digit, 0..9
//   ovf        out  1   committed value was greater than MAX_VAL
//   busy       out  1   conversion in progress
//   done       out  1   one-cycle pulse when digits/ovf commit
// -----------------------------------------------------------------------------
module out_port_bcd #(
  parameter logic [31:0] PORT_ADDR = 32'h0000_00C0,
  // Tied to the 7-bit binary / 2-digit BCD datapath below; changing it
  // requires widening the converter.
  parameter int unsigned MAX_VAL   = 99
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  output logic [31:0] port_data,
  output logic [3:0]  digit_ten,
  output logic [3:0]  digit_mod,
  output logic        ovf,
  output logic        busy,
  output logic        done
);

  localparam int unsigned BIN_W   = 7;
  localparam int unsigned DIGITS  = 2;
  localparam int unsigned BCD_W   = 4 * DIGITS;
  localparam logic [2:0]  LAST_IT = 3'(BIN_W - 1);
  localparam logic [31:0] MAX_W   = 32'(MAX_VAL);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             state_q;
  logic [31:0]        port_data_q;
  logic [BIN_W-1:0]   bin_q;
  logic [BCD_W-1:0]   bcd_q;
  logic [2:0]         cnt_q;
  logic               ov_pend_q;
  logic [3:0]         digit_ten_q;
  logic [3:0]         digit_mod_q;
  logic               ovf_q;
  logic               busy_q;
  logic               done_q;

  // Write decode and input saturation.
  logic               wr_hit;
  logic               over_max;
  logic [BIN_W-1:0]   clamp_d;

  assign wr_hit   = we && (addr == PORT_ADDR);
  assign over_max = (wdata > MAX_W);
  assign clamp_d  = over_max ? MAX_W[BIN_W-1:0] : wdata[BIN_W-1:0];

  // One double-dabble iteration: correct every nibble that would overflow
  // past 9 after doubling, then shift the whole {bcd, bin} register left.
  logic [BCD_W-1:0]   bcd_adj;
  logic [BCD_W-1:0]   bcd_d;
  logic [BIN_W-1:0]   bin_d;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5)
                                  ? (bcd_q[gi*4 +: 4] + 4'd3)
                                  : bcd_q[gi*4 +: 4];
    end
  endgenerate

  // The adjusted MSB is always 0 for inputs <= 99, so dropping it is safe.
  assign bcd_d = {bcd_adj[BCD_W-2:0], bin_q[BIN_W-1]};
  assign bin_d = {bin_q[BIN_W-2:0], 1'b0};

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      port_data_q <= '0;
      bin_q       <= '0;
      bcd_q       <= '0;
      cnt_q       <= '0;
      ov_pend_q   <= 1'b0;
      digit_ten_q <= '0;
      digit_mod_q <= '0;
      ovf_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (wr_hit) begin
        // A new write always wins, including on the completion edge: the
        // in-flight conversion is abandoned without committing.
        port_data_q <= wdata;
        bin_q       <= clamp_d;
        ov_pend_q   <= over_max;
        bcd_q       <= '0;
        cnt_q       <= '0;
        state_q     <= SHIFT;
        busy_q      <= 1'b1;
      end else begin
        case (state_q)
          SHIFT: begin
            bin_q <= bin_d;
            bcd_q <= bcd_d;
            if (cnt_q == LAST_IT) begin
              // Commit from the post-shift value of this final iteration.
              digit_ten_q <= bcd_d[7:4];
              digit_mod_q <= bcd_d[3:0];
              ovf_q       <= ov_pend_q;
              done_q      <= 1'b1;
              busy_q      <= 1'b0;
              cnt_q       <= '0;
              state_q     <= IDLE;
            end else begin
              cnt_q <= cnt_q + 3'd1;
            end
          end
          default: begin
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign port_data = port_data_q;
  assign digit_ten = digit_ten_q;
  assign digit_mod = digit_mod_q;
  assign ovf       = ovf_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
